// File: rtl/wash_seq.sv
// Washer program sequencer: runs the enabled stages in ascending order, each for
// its programmed number of time units, with pause/resume, a door interlock,
// abort, and a timed hold in END before the done level asserts.
module wash_seq #(
    parameter int NSTG     = 3,
    parameter int TW       = 6,
    parameter int TIM_CMAX = 50000,
    parameter int END_CMAX = 500000,
    localparam int UW      = TW + $clog2(NSTG) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tr_run,
    input  logic               tr_set,
    input  logic               door_open,
    input  logic [NSTG-1:0]    sel,
    input  logic [NSTG*TW-1:0] dur,
    output logic [NSTG-1:0]    stg_oh,
    output logic [NSTG-1:0]    stg_done,
    output logic [TW-1:0]      u_cur,
    output logic [UW-1:0]      u_tot,
    output logic               busy,
    output logic               paused,
    output logic               prog_done,
    output logic               done
);

    localparam int TCW = $clog2(TIM_CMAX);
    localparam int ECW = $clog2(END_CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_END   = 2'd3
    } state_t;

    // Isolate the lowest set bit of a stage mask.
    function automatic logic [NSTG-1:0] lowest_bit(input logic [NSTG-1:0] x);
        return x & (~x + NSTG'(1));
    endfunction

    // Duration of the stage selected by a one-hot (or zero) mask.
    function automatic logic [TW-1:0] dur_sel(input logic [NSTG-1:0] oh,
                                              input logic [NSTG*TW-1:0] d);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < NSTG; i++) begin
            r = r | (d[i*TW +: TW] & {TW{oh[i]}});
        end
        return r;
    endfunction

    // Enabled stages that also have a non-zero duration.
    function automatic logic [NSTG-1:0] eff_mask(input logic [NSTG-1:0] s,
                                                 input logic [NSTG*TW-1:0] d);
        logic [NSTG-1:0] m;
        m = '0;
        for (int i = 0; i < NSTG; i++) begin
            m[i] = s[i] & (|d[i*TW +: TW]);
        end
        return m;
    endfunction

    // Total units over the stages of a mask.
    function automatic logic [UW-1:0] sum_dur(input logic [NSTG-1:0] m,
                                              input logic [NSTG*TW-1:0] d);
        logic [UW-1:0] s;
        s = '0;
        for (int i = 0; i < NSTG; i++) begin
            s = s + (UW'(d[i*TW +: TW]) & {UW{m[i]}});
        end
        return s;
    endfunction

    state_t             state_r, state_n;
    logic [TCW-1:0]     tick_r, tick_n;
    logic [ECW-1:0]     end_cnt_r, end_cnt_n;
    logic [NSTG-1:0]    eff_r, eff_n;
    logic [NSTG*TW-1:0] dur_r, dur_n;
    logic [NSTG-1:0]    stg_oh_r, stg_oh_n;
    logic [NSTG-1:0]    stg_done_r, stg_done_n;
    logic [TW-1:0]      u_cur_r, u_cur_n;
    logic [UW-1:0]      u_tot_r, u_tot_n;
    logic               prog_done_r, prog_done_n;
    logic               done_r, done_n;

    logic [NSTG-1:0]    eff_in_s;
    logic [UW-1:0]      preview_s;
    logic [NSTG-1:0]    first_oh_s;
    logic [NSTG-1:0]    next_oh_s;

    assign eff_in_s   = eff_mask(sel, dur);
    assign preview_s  = sum_dur(eff_in_s, dur);
    assign first_oh_s = lowest_bit(eff_in_s);
    // Bits strictly above the active stage, restricted to the latched program.
    assign next_oh_s  = lowest_bit(eff_r & ~((stg_oh_r << 1) - NSTG'(1)));

    // Next-state and next-value logic for the whole sequencer.
    always_comb begin
        state_n     = state_r;
        tick_n      = tick_r;
        end_cnt_n   = end_cnt_r;
        eff_n       = eff_r;
        dur_n       = dur_r;
        stg_oh_n    = stg_oh_r;
        stg_done_n  = stg_done_r;
        u_cur_n     = u_cur_r;
        u_tot_n     = u_tot_r;
        prog_done_n = 1'b0;
        done_n      = done_r;

        case (state_r)
            S_IDLE: begin
                tick_n     = '0;
                end_cnt_n  = '0;
                stg_oh_n   = '0;
                stg_done_n = '0;
                u_cur_n    = '0;
                u_tot_n    = '0;
                done_n     = 1'b0;
                if (tr_run && !tr_set && !door_open && (eff_in_s != '0)) begin
                    state_n  = S_RUN;
                    eff_n    = eff_in_s;
                    dur_n    = dur;
                    stg_oh_n = first_oh_s;
                    u_cur_n  = dur_sel(first_oh_s, dur);
                    u_tot_n  = preview_s;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                if (tr_set) begin
                    state_n    = S_IDLE;
                    tick_n     = '0;
                    end_cnt_n  = '0;
                    stg_oh_n   = '0;
                    stg_done_n = '0;
                    u_cur_n    = '0;
                    u_tot_n    = '0;
                    done_n     = 1'b0;
                end else if (door_open || tr_run) begin
                    // Pausing wins over a unit tick: every counter holds.
                    state_n = S_PAUSE;
                end else if (tick_r == TCW'(TIM_CMAX - 1)) begin
                    tick_n  = '0;
                    u_tot_n = u_tot_r - UW'(1);
                    if (u_cur_r == TW'(1)) begin
                        prog_done_n = 1'b1;
                        stg_done_n  = stg_done_r | stg_oh_r;
                        if (next_oh_s != '0) begin
                            stg_oh_n = next_oh_s;
                            u_cur_n  = dur_sel(next_oh_s, dur_r);
                        end else begin
                            state_n   = S_END;
                            stg_oh_n  = '0;
                            u_cur_n   = '0;
                            u_tot_n   = '0;
                            end_cnt_n = '0;
                        end
                    end else begin
                        u_cur_n = u_cur_r - TW'(1);
                    end
                end else begin
                    tick_n = tick_r + TCW'(1);
                end
            end
            S_PAUSE: begin
                if (tr_set) begin
                    state_n    = S_IDLE;
                    tick_n     = '0;
                    end_cnt_n  = '0;
                    stg_oh_n   = '0;
                    stg_done_n = '0;
                    u_cur_n    = '0;
                    u_tot_n    = '0;
                    done_n     = 1'b0;
                end else if (tr_run && !door_open) begin
                    state_n = S_RUN;
                end else begin
                    state_n = S_PAUSE;
                end
            end
            S_END: begin
                if (tr_set || tr_run) begin
                    state_n    = S_IDLE;
                    tick_n     = '0;
                    end_cnt_n  = '0;
                    stg_oh_n   = '0;
                    stg_done_n = '0;
                    u_cur_n    = '0;
                    u_tot_n    = '0;
                    done_n     = 1'b0;
                end else if (end_cnt_r != ECW'(END_CMAX)) begin
                    end_cnt_n = end_cnt_r + ECW'(1);
                    done_n    = (end_cnt_r == ECW'(END_CMAX - 1));
                end else begin
                    done_n = 1'b1;
                end
            end
            default: begin
                state_n    = S_IDLE;
                tick_n     = '0;
                end_cnt_n  = '0;
                stg_oh_n   = '0;
                stg_done_n = '0;
                u_cur_n    = '0;
                u_tot_n    = '0;
                done_n     = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            tick_r      <= '0;
            end_cnt_r   <= '0;
            eff_r       <= '0;
            dur_r       <= '0;
            stg_oh_r    <= '0;
            stg_done_r  <= '0;
            u_cur_r     <= '0;
            u_tot_r     <= '0;
            prog_done_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            tick_r      <= tick_n;
            end_cnt_r   <= end_cnt_n;
            eff_r       <= eff_n;
            dur_r       <= dur_n;
            stg_oh_r    <= stg_oh_n;
            stg_done_r  <= stg_done_n;
            u_cur_r     <= u_cur_n;
            u_tot_r     <= u_tot_n;
            prog_done_r <= prog_done_n;
            done_r      <= done_n;
        end
    end

    assign stg_oh    = stg_oh_r;
    assign stg_done  = stg_done_r;
    assign u_cur     = u_cur_r;
    // IDLE shows a live preview of the program that would start.
    assign u_tot     = (state_r == S_IDLE) ? preview_s : u_tot_r;
    assign busy      = (state_r == S_RUN) || (state_r == S_PAUSE);
    assign paused    = (state_r == S_PAUSE);
    assign prog_done = prog_done_r;
    assign done      = done_r;

endmodule

// File: tb/tb_wash_seq.sv
// Scoreboard bench for wash_seq: each program's expected stage-completion and
// done events are computed from the stage list and pushed at start; a monitor
// pops and compares whenever prog_done pulses or done rises.
module tb_wash_seq;

    localparam int NSTG = 3;
    localparam int TW   = 6;
    localparam int TIM  = 4;
    localparam int ENDC = 8;
    localparam int UW   = TW + $clog2(NSTG) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tr_run = 1'b0;
    logic               tr_set = 1'b0;
    logic               door_open = 1'b0;
    logic [NSTG-1:0]    sel = '0;
    logic [NSTG*TW-1:0] dur = '0;
    logic [NSTG-1:0]    stg_oh;
    logic [NSTG-1:0]    stg_done;
    logic [TW-1:0]      u_cur;
    logic [UW-1:0]      u_tot;
    logic               busy;
    logic               paused;
    logic               prog_done;
    logic               done;

    wash_seq #(.NSTG(NSTG), .TW(TW), .TIM_CMAX(TIM), .END_CMAX(ENDC)) dut (
        .clk(clk), .rst_n(rst_n), .tr_run(tr_run), .tr_set(tr_set),
        .door_open(door_open), .sel(sel), .dur(dur), .stg_oh(stg_oh),
        .stg_done(stg_done), .u_cur(u_cur), .u_tot(u_tot), .busy(busy),
        .paused(paused), .prog_done(prog_done), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_done;
        int oh;
        int sd;
        int ucur;
        int utot;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    logic done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Monitor: every prog_done pulse and done rising edge consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && (prog_done || (done && !done_q))) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got prog_done=%0d done=%0d expected none (cycle %0d)",
                         prog_done, done, cyc);
            end else begin
                mon_ev = sb.pop_front();
                chk("ev_kind", done, mon_ev.is_done);
                chk("ev_cycle", cyc, mon_ev.cyc);
                chk("ev_stg_oh", stg_oh, mon_ev.oh);
                chk("ev_stg_done", stg_done, mon_ev.sd);
                chk("ev_u_cur", u_cur, mon_ev.ucur);
                chk("ev_u_tot", u_tot, mon_ev.utot);
            end
        end
        done_q = rst_n ? done : 1'b0;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One program: mode 0 plain, 1 pause by tr_run, 2 pause by door, 3 abort (run+set).
    task automatic run_prog(input logic [2:0] s, input logic [17:0] d, input int mode);
        int stg_q[$];
        int dq[$];
        int tot, t_units, k, L, lost, S, cum, j, nx, sd, e, ue, target, mask;
        ev_t ev;
        sel = s;
        dur = d;
        #1;
        tot  = 0;
        mask = 0;
        for (int i = 0; i < NSTG; i++) begin
            if (s[i] && (d[i*TW +: TW] != 0)) begin
                stg_q.push_back(i);
                dq.push_back(int'(d[i*TW +: TW]));
                tot  += int'(d[i*TW +: TW]);
                mask |= (1 << i);
            end
        end
        chk("idle_preview", u_tot, tot);
        if (stg_q.size() == 0) begin
            tr_run = 1'b1;
            step(1);
            tr_run = 1'b0;
            chk("nostart_busy", busy, 0);
            chk("nostart_oh", stg_oh, 0);
            return;
        end
        t_units = TIM * tot;
        k = (mode != 0) ? $urandom_range(1, t_units - 1) : 0;
        L = (mode == 1) ? $urandom_range(1, 12) : $urandom_range(3, 12);
        lost = (mode == 1 || mode == 2) ? L + 1 : 0;
        S = cyc + 1;
        cum = 0;
        sd = 0;
        for (int p = 0; p < stg_q.size(); p++) begin
            cum += dq[p];
            j = TIM * cum;
            if (mode == 3 && j >= k) break;
            nx = (p + 1 < stg_q.size()) ? p + 1 : -1;
            sd |= (1 << stg_q[p]);
            ev.cyc     = S + j + ((lost != 0 && j >= k) ? lost : 0);
            ev.is_done = 1'b0;
            ev.oh      = (nx >= 0) ? (1 << stg_q[nx]) : 0;
            ev.sd      = sd;
            ev.ucur    = (nx >= 0) ? dq[nx] : 0;
            ev.utot    = tot - cum;
            sb.push_back(ev);
        end
        target = S + t_units + lost + ENDC;
        if (mode != 3) begin
            ev.cyc = target; ev.is_done = 1'b1; ev.oh = 0;
            ev.sd = mask; ev.ucur = 0; ev.utot = 0;
            sb.push_back(ev);
        end
        tr_run = 1'b1;
        step(1);
        tr_run = 1'b0;
        chk("start_oh", stg_oh, 1 << stg_q[0]);
        chk("start_u_cur", u_cur, dq[0]);
        chk("start_busy", busy, 1);
        // Post-start input changes must not affect the running program.
        sel = 3'($urandom);
        dur = 18'($urandom);
        if (mode != 0) begin
            step(k - 1);
            // Units consumed before the interrupting edge, and the expected hold values.
            e = (k - 1) / TIM;
            ue = 0;
            cum = 0;
            for (int p = 0; p < dq.size(); p++) begin
                if (ue == 0 && e < cum + dq[p]) ue = cum + dq[p] - e;
                cum += dq[p];
            end
            if (mode == 3) begin
                tr_run = 1'b1; tr_set = 1'b1;
                step(1);
                tr_run = 1'b0; tr_set = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_stg_done", stg_done, 0);
                chk("abort_u_cur", u_cur, 0);
                step(2);
            end else if (mode == 1) begin
                tr_run = 1'b1;
                step(1);
                tr_run = 1'b0;
                step(L - 1);
                chk("pause_flag", paused, 1);
                chk("pause_u_cur", u_cur, ue);
                chk("pause_u_tot", u_tot, tot - e);
                tr_run = 1'b1;
                step(1);
                tr_run = 1'b0;
                chk("resume_flag", paused, 0);
            end else begin
                door_open = 1'b1;
                step(1);
                tr_run = 1'b1;
                step(1);
                tr_run = 1'b0;
                chk("door_hold_pause", paused, 1);
                step(L - 2);
                chk("door_u_cur", u_cur, ue);
                chk("door_u_tot", u_tot, tot - e);
                door_open = 1'b0;
                tr_run = 1'b1;
                step(1);
                tr_run = 1'b0;
                chk("door_resume", paused, 0);
            end
        end
        if (mode != 3) begin
            while (cyc < target + 2) step(1);
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_u_tot", u_tot, 0);
            chk("end_stg_done", stg_done, mask);
            if ($urandom_range(0, 1) == 1) tr_set = 1'b1;
            else tr_run = 1'b1;
            step(1);
            tr_set = 1'b0;
            tr_run = 1'b0;
            chk("exit_done", done, 0);
            chk("exit_stg_done", stg_done, 0);
        end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        step(2);
        chk("rst_oh", stg_oh, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_u_tot", u_tot, 0);
        rst_n = 1'b1;
        step(2);

        run_prog(3'b111, {6'd2, 6'd3, 6'd1}, 0);
        run_prog(3'b111, {6'd2, 6'd3, 6'd1}, 1);
        run_prog(3'b111, {6'd2, 6'd3, 6'd1}, 2);
        run_prog(3'b101, {6'd1, 6'd5, 6'd2}, 0);
        run_prog(3'b111, {6'd2, 6'd3, 6'd1}, 3);
        run_prog(3'b000, {6'd2, 6'd3, 6'd1}, 0);
        run_prog(3'b111, {6'd0, 6'd0, 6'd0}, 0);

        // Door held closed-out at start blocks the program.
        sel = 3'b011; dur = {6'd0, 6'd2, 6'd2}; door_open = 1'b1; tr_run = 1'b1;
        step(1);
        tr_run = 1'b0; door_open = 1'b0;
        chk("door_blocks_start", busy, 0);

        // Asynchronous reset in the middle of a stage.
        sel = 3'b111; dur = {6'd5, 6'd5, 6'd5}; tr_run = 1'b1;
        step(1);
        tr_run = 1'b0;
        step(7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_oh", stg_oh, 0);
        chk("arst_u_cur", u_cur, 0);
        chk("arst_u_tot_preview", u_tot, 15);
        step(1);
        rst_n = 1'b1;
        step(1);

        for (int r = 0; r < 24; r++) begin
            logic [17:0] dr;
            for (int i = 0; i < NSTG; i++) dr[i*TW +: TW] = 6'($urandom_range(0, 4));
            run_prog(3'($urandom), dr, $urandom_range(0, 3));
            step($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
